// File: rtl/alu_rsp_sched_if.sv
// Bundle of signals between the ALU sub-unit commit ports, the response
// scheduler and the downstream gather stage.
interface alu_rsp_sched_if #(
    parameter int NUM_INPUTS = 3,
    parameter int DATAW      = 64,
    parameter int SEL_W      = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
);
    logic [NUM_INPUTS-1:0]       valid_in;
    logic [NUM_INPUTS-1:0]       ready_in;
    logic [NUM_INPUTS*DATAW-1:0] data_in;
    logic                        valid_out;
    logic                        ready_out;
    logic [DATAW-1:0]            data_out;
    logic [SEL_W-1:0]            sel_out;
    logic [15:0]                 starve_cnt;

    // Sources and the downstream consumer together form the master side.
    modport master (
        output valid_in, data_in, ready_out,
        input  ready_in, valid_out, data_out, sel_out, starve_cnt
    );

    // The scheduler itself.
    modport slave (
        input  valid_in, data_in, ready_out,
        output ready_in, valid_out, data_out, sel_out, starve_cnt
    );
endinterface

// File: rtl/alu_rsp_sched.sv
// Merges the commit streams of the ALU sub-units into one registered commit
// stream. Round-robin arbitration, with an input that has lost MAX_STALL
// arbitrations in a row taking absolute priority (lowest index first).
module alu_rsp_sched #(
    parameter int NUM_INPUTS = 3,
    parameter int DATAW      = 64,
    parameter int MAX_STALL  = 15,
    parameter int SEL_W      = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1,
    parameter int CNT_W      = $clog2(MAX_STALL + 1)
) (
    input logic            clk,
    input logic            reset,
    alu_rsp_sched_if.slave bus
);
    // One extra bit so pointer + offset can exceed NUM_INPUTS before wrapping.
    localparam int IDX_W = SEL_W + 1;

    logic                  space;
    logic                  grant_valid;
    logic                  grant_forced;
    logic [SEL_W-1:0]      grant_idx;
    logic [NUM_INPUTS-1:0] forced_vec;
    logic [DATAW-1:0]      data_arr [NUM_INPUTS];

    logic                  valid_out_reg;
    logic [DATAW-1:0]      data_out_reg;
    logic [SEL_W-1:0]      sel_out_reg;
    logic [15:0]           starve_cnt_reg;
    logic [SEL_W-1:0]      rr_ptr_reg;

    // The output register can take a new beat when empty or draining now.
    assign space = !valid_out_reg || bus.ready_out;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_INPUTS; gi++) begin : g_in
            logic [CNT_W-1:0] wait_reg;

            assign data_arr[gi]     = bus.data_in[gi*DATAW +: DATAW];
            assign forced_vec[gi]   = bus.valid_in[gi] && (wait_reg == CNT_W'(MAX_STALL));
            assign bus.ready_in[gi] = grant_valid && (grant_idx == SEL_W'(gi));

            // Consecutive-loss counter: only moves on cycles where someone is granted.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    wait_reg <= '0;
                end else if (grant_valid) begin
                    if (grant_idx == SEL_W'(gi)) begin
                        wait_reg <= '0;
                    end else if (bus.valid_in[gi]) begin
                        if (wait_reg != CNT_W'(MAX_STALL)) begin
                            wait_reg <= wait_reg + CNT_W'(1);
                        end
                    end else begin
                        wait_reg <= '0;
                    end
                end
            end
        end
    endgenerate

    // Grant selection: starving inputs first, otherwise round-robin from the pointer.
    always_comb begin
        logic [IDX_W-1:0] idx;
        logic [SEL_W-1:0] cand;
        grant_valid  = 1'b0;
        grant_forced = 1'b0;
        grant_idx    = '0;
        idx          = '0;
        cand         = '0;
        if (space) begin
            // Descending scan so the smallest offset from the pointer wins.
            for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
                idx = {1'b0, rr_ptr_reg} + IDX_W'(k);
                if (idx >= IDX_W'(NUM_INPUTS)) begin
                    idx = idx - IDX_W'(NUM_INPUTS);
                end
                cand = idx[SEL_W-1:0];
                if (bus.valid_in[cand]) begin
                    grant_valid = 1'b1;
                    grant_idx   = cand;
                end
            end
            if (|forced_vec) begin
                grant_forced = 1'b1;
                for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
                    if (forced_vec[k]) begin
                        grant_idx = SEL_W'(k);
                    end
                end
            end
        end
    end

    // Output register: load on grant, drain on accept, otherwise hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_out_reg <= 1'b0;
            data_out_reg  <= '0;
            sel_out_reg   <= '0;
        end else if (grant_valid) begin
            valid_out_reg <= 1'b1;
            data_out_reg  <= data_arr[grant_idx];
            sel_out_reg   <= grant_idx;
        end else if (bus.ready_out) begin
            valid_out_reg <= 1'b0;
        end
    end

    // Round-robin pointer moves just past whichever input was granted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_reg <= '0;
        end else if (grant_valid) begin
            if (grant_idx == SEL_W'(NUM_INPUTS - 1)) begin
                rr_ptr_reg <= '0;
            end else begin
                rr_ptr_reg <= grant_idx + SEL_W'(1);
            end
        end
    end

    // Saturating count of starvation-forced grants.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt_reg <= '0;
        end else if (grant_valid && grant_forced && (starve_cnt_reg != 16'hFFFF)) begin
            starve_cnt_reg <= starve_cnt_reg + 16'd1;
        end
    end

    assign bus.valid_out  = valid_out_reg;
    assign bus.data_out   = data_out_reg;
    assign bus.sel_out    = sel_out_reg;
    assign bus.starve_cnt = starve_cnt_reg;
endmodule

// File: doc/alu_rsp_sched.md
Name: alu_rsp_sched

Overview:
- Response scheduler that merges commit streams from the ALU sub-units (integer, reduce, optional muldiv) of one ALU block into a single registered commit stream.
- Arbitration is round-robin with starvation protection: an input that loses arbitration MAX_STALL times in a row gets absolute priority.
- Sits between the sub-unit commit interfaces and the per-block gather stage.
- Exposes the granted source index and a saturating count of forced (starvation) grants for performance monitoring.

Parameters:
- NUM_INPUTS, 3, number of requesting sub-units (1..8).
- DATAW, 64, payload width per input in bits.
- MAX_STALL, 15, consecutive lost arbitrations before an input is forced (1..255).
- SEL_W, `UP(`CLOG2(NUM_INPUTS)), width of the select output (derived).
- CNT_W, `CLOG2(MAX_STALL+1), width of the per-input wait counter (derived).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- valid_in  in  NUM_INPUTS  request valid per input.
- ready_in  out  NUM_INPUTS  grant/accept per input; a transfer occurs when valid_in[i] && ready_in[i].
- data_in  in  NUM_INPUTS*DATAW  payloads; input i occupies bits [i*DATAW +: DATAW].
- valid_out  out  1  registered output valid.
- ready_out  in  1  downstream accept.
- data_out  out  DATAW  registered payload.
- sel_out  out  SEL_W  index of the input that produced data_out.
- starve_cnt  out  16  saturating count of starvation-forced grants.

Behaviour:
- Reset (async assert, sync release):
  - valid_out=0, data_out=0, sel_out=0, starve_cnt=0.
  - RR pointer=0, all wait counters=0.
  - ready_in is combinational and reads 0 only when it is blocked by output state.
- Space condition: space = !valid_out || ready_out. With no space, ready_in is all-zero, no grant occurs and no counter changes.
- Arbitration (combinational, only when space=1):
  - Forced set F = {i : valid_in[i] && wait[i]==MAX_STALL}.
  - If F is non-empty, grant the lowest index in F and mark the grant forced.
  - Otherwise grant the first valid input at or after the RR pointer, searching ascending with wrap-around.
  - ready_in is one-hot on the granted index, zero if nothing is valid.
- Output register:
  - On a grant, the next edge loads data_out=data_in[g], sel_out=g, valid_out=1.
  - Else if ready_out, valid_out goes to 0; data_out and sel_out hold their values.
  - Latency is 1 cycle from accept to valid_out.
  - Throughput is 1 per cycle with ready_out held high (pass-through when the register drains on the same cycle).
  - While valid_out && !ready_out, data_out and sel_out are held stable.
- RR pointer: on any grant (forced or not), pointer = (g+1) mod NUM_INPUTS. Unchanged otherwise.
- Wait counters, updated on edges with space=1:
  - Granted input: reset to 0.
  - Input with valid_in=1 that is not granted while another input was granted: increment, saturating at MAX_STALL.
  - Input with valid_in=0: cleared to 0.
  - No grant on the cycle (nothing valid): all counters hold.
- starve_cnt: increments on each forced grant and saturates at 16'hFFFF.
- Input protocol:
  - Sources must hold valid_in and data_in until accepted.
  - Dropping valid_in early is a protocol error; the design tolerates it and clears that input's counter.
- NUM_INPUTS=1: pass-through register, sel_out=0. Counters never increment.
- Reset asserted mid-transfer: the output entry is discarded immediately. Sources must re-present their requests.

Test Plan:
- Reset then idle: assert reset with all valid_in=0 -> valid_out=0, sel_out=0, starve_cnt=0, ready_in=3'b000 at every edge.
- Fairness: all three inputs held valid, ready_out=1 -> sel_out sequence 0,1,2,0,1,2 with one output per cycle, data_out matching the selected input's payload, starve_cnt=0.
- Backpressure: one beat captured, then ready_out=0 for 5 cycles -> data_out/sel_out stable, ready_in=0, counters frozen. ready_out=1 -> next beat accepted the same cycle.
- Starvation (MAX_STALL=2, NUM_INPUTS=3):
  - Stimulus: inputs 0 and 1 toggle valid so they keep winning (input 1 always presents right after input 0 is granted); input 2 is held valid.
  - Required: input 2 is granted no later than its third arbitration round, and starve_cnt increments only on forced grants.
- Saturation: force starve_cnt to 16'hFFFE via a long starvation run -> it reaches 16'hFFFF and holds there.
- Async reset mid-stream: assert reset while valid_out=1 and ready_out=0 -> valid_out drops without waiting for a clock edge. After release, the first grant is lowest-index-first from pointer 0.
